manch_tx_encoder: RTL and testbench

// - 10 Mb/s Manchester transmit stage in CommsFPGA_top, between the MAC MII TX interface and the manch_out_p/n pad pair.
// - Generates the MII transmit clock for the MAC (which drives mac_mii_txd / mac_mii_tx_en onto it).
// - Samples each nibble, serialises it LSB first and Manchester-encodes it at half-bit rate.
// - Appends the end-of-frame high hold; reports carrier and frame/error counters to the debug taps.

---
 rtl/comms_mii_pkg.sv | 17 +
 rtl/mii_tx_clk_gen.sv | 35 +++
 rtl/manch_tx_encoder.sv | 139 +++++++++++++
 tb/tb_manch_tx_encoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/comms_mii_pkg.sv
// Shared types and constants for the 10 Mb/s Manchester MII transmit path.
package comms_mii_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    EOF  = 2'd2
  } tx_state_e;

  localparam int unsigned NIBBLE_W         = 4;
  localparam int unsigned NIBBLE_HALFBITS  = 8;
  localparam int unsigned MII_DIV          = 8;
  localparam int unsigned DIV_W            = $clog2(MII_DIV);
  localparam int unsigned EOF_HALFBITS_DEF = 4;
  localparam int unsigned EOF_CNT_W        = 3;

endpackage

// File: rtl/mii_tx_clk_gen.sv
// Divides the half-bit clock by 8 to make the MII TX clock and the nibble sample strobe.
module mii_tx_clk_gen
  import comms_mii_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [DIV_W-1:0] div_cnt,
  output logic             mii_tx_clk,
  output logic             strobe_c
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             mii_tx_clk_q, mii_tx_clk_d;

  // MII clock is high for the upper half of the divider count.
  always_comb begin
    div_cnt_d    = div_cnt_q + DIV_W'(1);
    mii_tx_clk_d = (div_cnt_d >= DIV_W'(MII_DIV / 2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      mii_tx_clk_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      mii_tx_clk_q <= mii_tx_clk_d;
    end
  end

  assign div_cnt    = div_cnt_q;
  assign mii_tx_clk = mii_tx_clk_q;
  assign strobe_c   = (div_cnt_q == DIV_W'(MII_DIV - 1));

endmodule

// File: rtl/manch_tx_encoder.sv
// MII nibble to Manchester line encoder with end-of-frame hold, carrier and debug counters.
module manch_tx_encoder
  import comms_mii_pkg::*;
#(
  parameter int unsigned EOF_HALFBITS = EOF_HALFBITS_DEF,
  parameter logic        IDLE_LEVEL   = 1'b0,
  parameter int unsigned FCNT_W       = 16,
  parameter int unsigned ECNT_W       = 8
) (
  input  logic                bit_clk2x,
  input  logic                reset,
  output logic                mii_tx_clk,
  input  logic [NIBBLE_W-1:0] mii_txd,
  input  logic                mii_tx_en,
  input  logic                mii_tx_er,
  output logic                manch_out_p,
  output logic                manch_out_n,
  output logic                tx_active,
  output logic [FCNT_W-1:0]   frame_cnt,
  output logic [ECNT_W-1:0]   txer_cnt
);

  logic [DIV_W-1:0]     div_cnt;
  logic                 strobe_c;

  tx_state_e            state_q, state_d;
  logic [EOF_CNT_W-1:0] eof_cnt_q, eof_cnt_d;
  logic [NIBBLE_W-1:0]  shreg_q, shreg_d;
  logic                 er_q, er_d;
  logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [ECNT_W-1:0]    txer_cnt_q, txer_cnt_d;
  logic                 p_q, p_d;
  logic                 n_q, n_d;
  logic                 active_q, active_d;
  logic                 bit_c;

  mii_tx_clk_gen u_clk_gen (
    .clk        (bit_clk2x),
    .rst        (reset),
    .div_cnt    (div_cnt),
    .mii_tx_clk (mii_tx_clk),
    .strobe_c   (strobe_c)
  );

  assign bit_c = shreg_q[div_cnt[DIV_W-1:1]];

  always_comb begin
    state_d     = state_q;
    eof_cnt_d   = eof_cnt_q;
    shreg_d     = shreg_q;
    er_d        = er_q;
    frame_cnt_d = frame_cnt_q;
    txer_cnt_d  = txer_cnt_q;
    p_d         = IDLE_LEVEL;
    n_d         = IDLE_LEVEL;
    active_d    = 1'b0;

    // Line output for the current half-bit, registered one cycle later.
    unique case (state_q)
      DATA: begin
        p_d      = er_q ? 1'b1 : (div_cnt[0] ? bit_c : ~bit_c);
        n_d      = ~p_d;
        active_d = 1'b1;
      end
      EOF: begin
        p_d      = 1'b1;
        n_d      = 1'b0;
        active_d = 1'b1;
      end
      default: ;
    endcase

    unique case (state_q)
      IDLE: begin
        if (strobe_c && mii_tx_en) begin
          state_d     = DATA;
          shreg_d     = mii_txd;
          er_d        = 1'b0;
          frame_cnt_d = frame_cnt_q + FCNT_W'(1);
        end
      end
      DATA: begin
        if (strobe_c) begin
          if (mii_tx_en) begin
            shreg_d = mii_txd;
            er_d    = mii_tx_er;
            if (mii_tx_er && (txer_cnt_q != {ECNT_W{1'b1}})) begin
              txer_cnt_d = txer_cnt_q + ECNT_W'(1);
            end
          end else begin
            state_d   = EOF;
            eof_cnt_d = '0;
            er_d      = 1'b0;
          end
        end
      end
      EOF: begin
        // Hold lasts EOF_HALFBITS cycles, always finishing before the next strobe.
        if (eof_cnt_q == EOF_CNT_W'(EOF_HALFBITS - 1)) begin
          state_d = IDLE;
        end else begin
          eof_cnt_d = eof_cnt_q + EOF_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bit_clk2x or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      eof_cnt_q   <= '0;
      shreg_q     <= '0;
      er_q        <= 1'b0;
      frame_cnt_q <= '0;
      txer_cnt_q  <= '0;
      p_q         <= IDLE_LEVEL;
      n_q         <= IDLE_LEVEL;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      eof_cnt_q   <= eof_cnt_d;
      shreg_q     <= shreg_d;
      er_q        <= er_d;
      frame_cnt_q <= frame_cnt_d;
      txer_cnt_q  <= txer_cnt_d;
      p_q         <= p_d;
      n_q         <= n_d;
      active_q    <= active_d;
    end
  end

  assign manch_out_p = p_q;
  assign manch_out_n = n_q;
  assign tx_active   = active_q;
  assign frame_cnt   = frame_cnt_q;
  assign txer_cnt    = txer_cnt_q;

endmodule

// File: tb/tb_manch_tx_encoder.sv
// Directed/randomised bench for manch_tx_encoder against a half-bit stream reference model.
module tb_manch_tx_encoder;

  localparam int unsigned EOF_H  = 4;
  localparam int unsigned FCNT_W = 16;
  localparam int unsigned ECNT_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mii_tx_clk;
  logic [3:0]        mii_txd = 4'h0;
  logic              mii_tx_en = 1'b0;
  logic              mii_tx_er = 1'b0;
  logic              manch_out_p, manch_out_n, tx_active;
  logic [FCNT_W-1:0] frame_cnt;
  logic [ECNT_W-1:0] txer_cnt;

  always #5 clk = ~clk;

  manch_tx_encoder #(
    .EOF_HALFBITS (EOF_H),
    .IDLE_LEVEL   (1'b0),
    .FCNT_W       (FCNT_W),
    .ECNT_W       (ECNT_W)
  ) dut (
    .bit_clk2x   (clk),
    .reset       (rst),
    .mii_tx_clk  (mii_tx_clk),
    .mii_txd     (mii_txd),
    .mii_tx_en   (mii_tx_en),
    .mii_tx_er   (mii_tx_er),
    .manch_out_p (manch_out_p),
    .manch_out_n (manch_out_n),
    .tx_active   (tx_active),
    .frame_cnt   (frame_cnt),
    .txer_cnt    (txer_cnt)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         exp_frames = 0;
  int         exp_txer   = 0;
  logic [3:0] nib_a [64];
  bit         er_a  [64];
  logic       rec_p [$];
  logic       rec_n [$];
  logic       rec_a [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    for (int k = 0; k < 64; k++) begin
      nib_a[k] = 4'($urandom_range(15, 0));
      er_a[k]  = 1'b0;
    end
  endtask

  // Drives n nibbles on mii_tx_clk rises and records the line from the first strobe onward.
  task automatic run_frame(input int n, input string name);
    int   len;
    int   rises;
    int   cyc;
    int   act_cnt;
    bit   started;
    logic prev;
    int   exp_p [$];
    int   exp_a [$];
    len     = 1 + 8 * n + EOF_H + 4;
    rises   = 0;
    cyc     = 0;
    started = 1'b0;
    prev    = mii_tx_clk;
    rec_p.delete(); rec_n.delete(); rec_a.delete();
    while (rec_p.size() < len && cyc < len + 40) begin
      step();
      cyc++;
      if (!prev && mii_tx_clk) begin
        if (rises < n) begin
          mii_txd   = nib_a[rises];
          mii_tx_en = 1'b1;
          mii_tx_er = er_a[rises];
        end else if (rises == n) begin
          mii_txd   = 4'($urandom_range(15, 0));
          mii_tx_en = 1'b0;
          mii_tx_er = 1'b0;
        end
        rises++;
      end else if (prev && !mii_tx_clk && rises > 0) begin
        started = 1'b1;
      end
      prev = mii_tx_clk;
      if (started) begin
        rec_p.push_back(manch_out_p);
        rec_n.push_back(manch_out_n);
        rec_a.push_back(tx_active);
      end
    end
    check({name, "_len"}, 32'(rec_p.size()), 32'(len));

    // Reference: idle strobe cycle, two half-bits per data bit LSB first, violation, EOF hold, idle.
    exp_p.push_back(0); exp_a.push_back(0);
    for (int k = 0; k < n; k++) begin
      if (k > 0 && er_a[k]) begin
        for (int h = 0; h < 8; h++) begin exp_p.push_back(1); exp_a.push_back(1); end
      end else begin
        for (int b = 0; b < 4; b++) begin
          exp_p.push_back(nib_a[k][b] ? 0 : 1); exp_a.push_back(1);
          exp_p.push_back(nib_a[k][b] ? 1 : 0); exp_a.push_back(1);
        end
      end
    end
    for (int h = 0; h < int'(EOF_H); h++) begin exp_p.push_back(1); exp_a.push_back(1); end
    for (int h = 0; h < 4; h++) begin exp_p.push_back(0); exp_a.push_back(0); end

    act_cnt = 0;
    for (int i = 0; i < rec_p.size(); i++) begin
      check($sformatf("%s_p[%0d]", name, i), 32'(rec_p[i]), 32'(exp_p[i]));
      check($sformatf("%s_n[%0d]", name, i), 32'(rec_n[i]),
            32'(exp_a[i] != 0 ? 1 - exp_p[i] : 0));
      check($sformatf("%s_act[%0d]", name, i), 32'(rec_a[i]), 32'(exp_a[i]));
      if (rec_a[i] === 1'b1) act_cnt++;
    end
    check({name, "_active_cycles"}, 32'(act_cnt), 32'(8 * n + int'(EOF_H)));

    exp_frames = (exp_frames + 1) % (1 << FCNT_W);
    for (int k = 1; k < n; k++) begin
      if (er_a[k] && exp_txer < 255) exp_txer++;
    end
    check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
    check({name, "_txer_cnt"}, 32'(txer_cnt), 32'(exp_txer));
  endtask

  initial begin
    int   rise_c [$];
    int   fall_c [$];
    logic prev;
    bit   done;
    int   rises;
    int   a_exp [13];

    // Reset state.
    repeat (3) step();
    check("rst_p", 32'(manch_out_p), 32'(0));
    check("rst_n", 32'(manch_out_n), 32'(0));
    check("rst_txclk", 32'(mii_tx_clk), 32'(0));
    check("rst_act", 32'(tx_active), 32'(0));
    check("rst_fcnt", 32'(frame_cnt), 32'(0));
    check("rst_ecnt", 32'(txer_cnt), 32'(0));
    @(negedge clk) rst = 1'b0;

    // Idle for 100 cycles, measure the MII clock shape.
    prev = mii_tx_clk;
    for (int c = 0; c < 100; c++) begin
      step();
      check($sformatf("idle_p[%0d]", c), 32'(manch_out_p), 32'(0));
      check($sformatf("idle_n[%0d]", c), 32'(manch_out_n), 32'(0));
      check($sformatf("idle_act[%0d]", c), 32'(tx_active), 32'(0));
      if (!prev && mii_tx_clk) rise_c.push_back(c);
      if (prev && !mii_tx_clk && rise_c.size() > 0) fall_c.push_back(c);
      prev = mii_tx_clk;
    end
    check("txclk_rises", 32'(rise_c.size() >= 3), 32'(1));
    if (rise_c.size() >= 3 && fall_c.size() >= 2) begin
      check("txclk_period0", 32'(rise_c[1] - rise_c[0]), 32'(8));
      check("txclk_period1", 32'(rise_c[2] - rise_c[1]), 32'(8));
      check("txclk_high", 32'(fall_c[0] - rise_c[0]), 32'(4));
      check("txclk_low", 32'(rise_c[1] - fall_c[0]), 32'(4));
    end

    // Single nibble 0xA.
    clear_frame();
    nib_a[0] = 4'hA;
    run_frame(1, "nibA");
    a_exp = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < 13; i++) begin
      if (i + 1 < rec_p.size()) check($sformatf("nibA_lit[%0d]", i), 32'(rec_p[i + 1]), 32'(a_exp[i]));
    end

    // 64-nibble frame.
    clear_frame();
    for (int k = 0; k < 15; k++) nib_a[k] = 4'h5;
    nib_a[15] = 4'hD;
    run_frame(64, "long");

    // tx_er on nibble 3 of 8.
    clear_frame();
    er_a[3] = 1'b1;
    run_frame(8, "txer");
    check("txer_one", 32'(txer_cnt), 32'(1));

    // Reset at half-bit 5 of a nibble.
    prev  = mii_tx_clk;
    rises = 0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (!prev && mii_tx_clk && rises == 0) begin
        mii_txd = 4'hF; mii_tx_en = 1'b1; mii_tx_er = 1'b0; rises = 1;
      end else if (prev && !mii_tx_clk && rises == 1) begin
        done = 1'b1;
      end
      prev = mii_tx_clk;
    end
    check("mid_strobe_seen", 32'(done), 32'(1));
    repeat (6) step();
    check("mid_hb5_p", 32'(manch_out_p), 32'(1));
    check("mid_hb5_act", 32'(tx_active), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_p", 32'(manch_out_p), 32'(0));
    check("mid_rst_n", 32'(manch_out_n), 32'(0));
    check("mid_rst_act", 32'(tx_active), 32'(0));
    check("mid_rst_txclk", 32'(mii_tx_clk), 32'(0));
    check("mid_rst_fcnt", 32'(frame_cnt), 32'(0));
    check("mid_rst_ecnt", 32'(txer_cnt), 32'(0));
    mii_tx_en = 1'b0;
    @(negedge clk) rst = 1'b0;
    exp_frames = 0;
    exp_txer   = 0;
    for (int c = 0; c < 16; c++) begin
      step();
      check($sformatf("post_rst_p[%0d]", c), 32'(manch_out_p), 32'(0));
      check($sformatf("post_rst_act[%0d]", c), 32'(tx_active), 32'(0));
    end
    clear_frame();
    run_frame(3, "resume");

    // 300 frames with tx_er on every nibble.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    exp_frames = 0;
    exp_txer   = 0;
    for (int f = 0; f < 300; f++) begin
      clear_frame();
      er_a[0] = 1'b1;
      er_a[1] = 1'b1;
      run_frame(2, $sformatf("sat%0d", f));
    end
    check("sat_frame_cnt", 32'(frame_cnt), 32'(300));
    check("sat_txer_cnt", 32'(txer_cnt), 32'(255));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
